mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Single-port memory arbiter and sequencer for the RV32I core. It shares one unified 4 KiW word memory between the instruction-fetch requester and the load/store requester. Data has fixed priority, with an anti-starvation override for fetch. It sits between the core datapath (PC fetch and ALU-result load/store) and the memory array, and generates grant and read-valid handshakes.

Parameters:
ADDR_W, 12, word-address width (memory depth 2**ADDR_W)
DATA_W, 32, data width; must be 32 (4 byte lanes)
MEM_LAT, 1, memory read latency in cycles after mem_en; legal range 1..7
STARVE_MAX, 3, consecutive fetch losses before fetch is forced to win; legal range 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch word address (PC[ADDR_W+1:2])
if_gnt  out  1  fetch granted this cycle
if_rvalid  out  1  fetch data valid pulse
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request, held until d_gnt
d_we  in  1  1=store, 0=load
d_be  in  4  byte enables (byte_masking)
d_addr  in  ADDR_W  data word address (Result[ADDR_W+1:2])
d_wdata  in  DATA_W  store data
d_gnt  out  1  data granted this cycle
d_rvalid  out  1  load data valid / store complete pulse
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  access in flight (state != IDLE)

Behaviour:
- Reset: state IDLE; all outputs 0; starvation count 0; owner register 0.
- FSM states: IDLE, WAIT.
- IDLE with no request: stay IDLE, no strobe.
- IDLE with any request: combinationally assert exactly one gnt. The same cycle drives mem_en=1 and the winner's addr/we/be/wdata onto the mem_* bus. Register the owner and load the latency counter with MEM_LAT, then go to WAIT.
- For fetch, mem_we=0 and mem_be=4'hF always.
- WAIT: decrement the counter each cycle. At the final cycle (counter==1), register mem_rdata into the owner's rdata and pulse the owner's rvalid for 1 cycle. Return to IDLE.
- A store also pulses d_rvalid as a completion ack; d_rdata is unchanged on a store.
- Total latency: grant to rvalid = MEM_LAT+1 cycles. Maximum throughput is one access per MEM_LAT+1 cycles. No grant is issued while in WAIT.
- Arbitration: d_req wins over if_req, unless starvation count == STARVE_MAX, in which case fetch wins.
- Starvation count increments (saturating) when if_req=1 and d wins. It clears on any fetch grant, and also clears when if_req=0 in IDLE.
- A req deasserted before its gnt is legal: no access, no rvalid.
- rdata outputs hold their last value until the next rvalid for that port.
- mem_* outputs other than mem_en are don't-care when mem_en=0 but must be driven (no X). They hold the last value.
- Reset asserted mid-WAIT: the access is abandoned, no rvalid is issued, and the FSM returns to IDLE asynchronously.
- Simultaneous if_req and d_req with count < STARVE_MAX: d_gnt=1, if_gnt=0, count+1.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: three extra output ports, each 32 bits and saturating at 32'hFFFF_FFFF:
  - perf_if_gnt: counts fetch grants.
  - perf_d_gnt: counts data grants.
  - perf_stall: counts cycles with (if_req|d_req) high and no gnt issued.
- All three reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WAIT);
  - the owner enum (OWN_IF, OWN_D);
  - the BE_FULL constant (4'hF);
  - DATA_W as a localparam.
- One sub-module, mem_arb_perf (the counter bank), is instantiated only under MEM_ARB_PERF_EN.
- Arbitration and the FSM stay in mem_arbiter.

Test Plan:
1. Reset and single fetch:
   - Stimulus: rst_n low 3 cycles; then if_req=1, if_addr=12'h010; mem model returns 32'h0000_0093.
   - Required: if_gnt=1 with mem_en=1 and mem_addr=12'h010 in the same cycle; if_rvalid=1 with if_rdata=32'h0000_0093 exactly 2 cycles later (MEM_LAT=1).
2. Store then load:
   - Stimulus: d_req, d_we=1, d_be=4'b0011, d_addr=12'h020, d_wdata=32'hDEAD_BEEF; then a load from 12'h020.
   - Required: mem_be=4'b0011 during the store; d_rvalid pulses for both accesses; d_rdata=32'h0000_BEEF from a zero-initialised model.
3. Contention:
   - Stimulus: if_req and d_req both held high continuously.
   - Required: grant order is D, D, D, IF, D, D, D, IF (STARVE_MAX=3); if_gnt and d_gnt are never high together.
4. Withdrawn request:
   - Stimulus: if_req high 1 cycle while in WAIT, then dropped.
   - Required: no if_gnt, no extra mem_en, no if_rvalid.
5. Reset mid-access:
   - Stimulus: assert rst_n low during WAIT.
   - Required: busy=0 immediately; no rvalid afterwards; the next request is granted normally.
6. Latency parameter and perf counters:
   - Stimulus: MEM_LAT=3 with MEM_ARB_PERF_EN defined; 10 fetches with if_req held high.
   - Required: each if_rvalid occurs 4 cycles after its if_gnt; perf_if_gnt=10; perf_stall=30 (3 non-granting WAIT cycles per access).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter slice.
package mem_arb_pkg;

  // Data width of the unified memory (four byte lanes)
  localparam int DATA_W = 32;

  // All byte lanes enabled (used for every fetch)
  localparam logic [3:0] BE_FULL = 4'hF;

  // Sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Requester that owns the access in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Saturating 32-bit increment used by the performance counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    logic [31:0] result;
    if (en && (value != 32'hFFFF_FFFF)) begin
      result = value + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side handshake bundle for mem_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = mem_arb_pkg::DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_perf.sv
// Saturating performance counter bank for mem_arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_gnt,
  input  logic        d_gnt,
  input  logic        stall,
  output logic [31:0] perf_if_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_stall
);

  logic [31:0] if_cnt_q, if_cnt_d;
  logic [31:0] d_cnt_q, d_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Next counter values, each saturating at all-ones
  always_comb begin
    if_cnt_d    = sat_inc32(if_cnt_q, if_gnt);
    d_cnt_d     = sat_inc32(d_cnt_q, d_gnt);
    stall_cnt_d = sat_inc32(stall_cnt_q, stall);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_cnt_q    <= 32'd0;
      d_cnt_q     <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if_cnt_q    <= if_cnt_d;
      d_cnt_q     <= d_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_if_gnt = if_cnt_q;
  assign perf_d_gnt  = d_cnt_q;
  assign perf_stall  = stall_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer: shares one word memory between
// instruction fetch and load/store. Data has priority; fetch is forced to
// win after STARVE_MAX consecutive losses. Grants are combinational in IDLE,
// read data returns MEM_LAT+1 cycles after the grant.
// Optional: define MEM_ARB_PERF_EN to add saturating perf counter ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus,
  output logic        busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_s, d_gnt_s, mem_en_s;

  // Arbitration, sequencing and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    mem_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM))) begin
          // Data wins; a waiting fetch loses one more round
          d_gnt_s     = 1'b1;
          mem_en_s    = 1'b1;
          owner_d     = OWN_D;
          mem_we_d    = bus.d_we;
          mem_be_d    = bus.d_be;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          cnt_d       = LAT_INIT;
          state_d     = WAIT;
          if (bus.if_req) begin
            if (starve_q != STARVE_LIM) begin
              starve_d = starve_q + 4'd1;
            end else begin
              starve_d = starve_q;
            end
          end else begin
            starve_d = 4'd0;
          end
        end else if (bus.if_req) begin
          // Fetch wins, either uncontended or by starvation override
          if_gnt_s    = 1'b1;
          mem_en_s    = 1'b1;
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = BE_FULL;
          mem_addr_d  = bus.if_addr;
          cnt_d       = LAT_INIT;
          state_d     = WAIT;
          starve_d    = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end else begin
            // Stores get a completion pulse but keep the old load data
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Grant/strobe and the mem bus reflect the winner in the grant cycle and
  // hold the previous access otherwise.
  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_be    = mem_be_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state_q == WAIT);

`ifdef MEM_ARB_PERF_EN
  logic stall_s;
  assign stall_s = (bus.if_req | bus.d_req) & ~(if_gnt_s | d_gnt_s);

  mem_arb_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_gnt      (if_gnt_s),
    .d_gnt       (d_gnt_s),
    .stall       (stall_s),
    .perf_if_gnt (perf_if_gnt),
    .perf_d_gnt  (perf_d_gnt),
    .perf_stall  (perf_stall)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A (MEM_LAT=1) with a byte-lane
// memory model, instance B (MEM_LAT=3) with a read-only 3-stage memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) aif ();
  mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bif ();
  logic a_busy, b_busy;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] a_pif, a_pd, a_ps, b_pif, b_pd, b_ps;
`endif

  mem_arbiter #(.ADDR_W(12), .MEM_LAT(1), .STARVE_MAX(3)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(aif.slave), .busy(a_busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_gnt(a_pif), .perf_d_gnt(a_pd), .perf_stall(a_ps)
`endif
  );

  mem_arbiter #(.ADDR_W(12), .MEM_LAT(3), .STARVE_MAX(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .busy(b_busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_gnt(b_pif), .perf_d_gnt(b_pd), .perf_stall(b_ps)
`endif
  );

  // Memory A: one-cycle read, byte-lane writes, zero except one instruction
  logic [31:0] mem_a [0:4095] = '{16: 32'h0000_0093, default: 32'h0};
  logic [31:0] a_rd = 32'h0;
  assign aif.mem_rdata = a_rd;
  always @(posedge clk) begin
    if (aif.mem_en) begin
      a_rd <= mem_a[aif.mem_addr];
      if (aif.mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (aif.mem_be[i]) mem_a[aif.mem_addr][8*i +: 8] <= aif.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Memory B: three-cycle read pipeline, word = A000_0000 | address
  logic [31:0] b_p1 = 32'h0, b_p2 = 32'h0, b_p3 = 32'h0;
  assign bif.mem_rdata = b_p3;
  always @(posedge clk) begin
    b_p1 <= bif.mem_en ? (32'hA000_0000 | {20'h0, bif.mem_addr}) : 32'h0;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int          ng, nrv, ev;
  int          gq [10];
  logic [7:0]  exp_seq;

  initial begin
    rst_n = 1'b0;
    aif.if_req = 1'b0; aif.if_addr = 12'h0; aif.d_req = 1'b0; aif.d_we = 1'b0;
    aif.d_be = 4'h0; aif.d_addr = 12'h0; aif.d_wdata = 32'h0;
    bif.if_req = 1'b0; bif.if_addr = 12'h0; bif.d_req = 1'b0; bif.d_we = 1'b0;
    bif.d_be = 4'h0; bif.d_addr = 12'h0; bif.d_wdata = 32'h0;

    // 1. reset state and a single fetch
    repeat (3) cyc();
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_mem_en", aif.mem_en, 0);
    check("rst_gnts", {aif.if_gnt, aif.d_gnt}, 0);
    check("rst_rvalids", {aif.if_rvalid, aif.d_rvalid}, 0);
    check("rst_if_rdata", aif.if_rdata, 0);
    check("rst_d_rdata", aif.d_rdata, 0);
    check("rst_mem_addr", aif.mem_addr, 0);
    check("rst_mem_be_we", {aif.mem_we, aif.mem_be}, 0);
    check("rst_mem_wdata", aif.mem_wdata, 0);
    check("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;

    cyc(); aif.if_req = 1'b1; aif.if_addr = 12'h010; #1;
    check("t1_if_gnt", aif.if_gnt, 1);
    check("t1_d_gnt", aif.d_gnt, 0);
    check("t1_mem_en", aif.mem_en, 1);
    check("t1_mem_addr", aif.mem_addr, 12'h010);
    check("t1_mem_we_be", {aif.mem_we, aif.mem_be}, 5'b0_1111);
    cyc(); aif.if_req = 1'b0; #1;
    check("t1_busy", a_busy, 1);
    check("t1_no_early_rv", aif.if_rvalid, 0);
    check("t1_wait_no_en", aif.mem_en, 0);
    cyc(); #1;
    check("t1_if_rvalid", aif.if_rvalid, 1);
    check("t1_if_rdata", aif.if_rdata, 32'h0000_0093);
    check("t1_idle", a_busy, 0);
    cyc(); #1;
    check("t1_rv_pulse", aif.if_rvalid, 0);
    check("t1_rdata_hold", aif.if_rdata, 32'h0000_0093);

    // 2. store then load
    cyc(); aif.d_req = 1'b1; aif.d_we = 1'b1; aif.d_be = 4'b0011;
    aif.d_addr = 12'h020; aif.d_wdata = 32'hDEAD_BEEF; #1;
    check("t2_st_gnt", aif.d_gnt, 1);
    check("t2_st_mem_be", aif.mem_be, 4'b0011);
    check("t2_st_mem_we", aif.mem_we, 1);
    check("t2_st_addr", aif.mem_addr, 12'h020);
    check("t2_st_wdata", aif.mem_wdata, 32'hDEAD_BEEF);
    cyc(); aif.d_req = 1'b0; #1;
    cyc(); #1;
    check("t2_st_ack", aif.d_rvalid, 1);
    check("t2_st_rdata_kept", aif.d_rdata, 0);
    aif.d_req = 1'b1; aif.d_we = 1'b0; aif.d_be = 4'hF; aif.d_addr = 12'h020; #1;
    check("t2_ld_gnt", aif.d_gnt, 1);
    cyc(); aif.d_req = 1'b0; #1;
    cyc(); #1;
    check("t2_ld_rvalid", aif.d_rvalid, 1);
    check("t2_ld_rdata", aif.d_rdata, 32'h0000_BEEF);

    // 3. contention: D,D,D,IF,D,D,D,IF
    exp_seq = 8'b0111_0111;
    ng = 0;
    cyc(); aif.if_req = 1'b1; aif.if_addr = 12'h010; aif.d_req = 1'b1; aif.d_addr = 12'h020;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("t3_exclusive", {31'h0, aif.if_gnt & aif.d_gnt}, 0);
      if (aif.if_gnt | aif.d_gnt) begin
        if (ng < 8) check("t3_order_is_d", aif.d_gnt, {31'h0, exp_seq[ng]});
        ng++;
      end
      cyc();
    end
    aif.if_req = 1'b0; aif.d_req = 1'b0;
    check("t3_grant_count", ng, 8);
    cyc(); cyc();

    // 4. fetch request raised in WAIT then withdrawn
    aif.d_req = 1'b1; aif.d_we = 1'b0; aif.d_addr = 12'h020; #1;
    check("t4_d_gnt", aif.d_gnt, 1);
    cyc(); aif.d_req = 1'b0; aif.if_req = 1'b1; aif.if_addr = 12'h030; #1;
    check("t4_wait_no_gnt", aif.if_gnt, 0);
    check("t4_wait_no_en", aif.mem_en, 0);
    cyc(); aif.if_req = 1'b0; #1;
    check("t4_d_rvalid", aif.d_rvalid, 1);
    check("t4_d_rdata", aif.d_rdata, 32'h0000_BEEF);
    ev = 0;
    for (int k = 0; k < 4; k++) begin
      if (aif.if_gnt | aif.mem_en | aif.if_rvalid) ev++;
      cyc(); #1;
    end
    check("t4_quiet", ev, 0);

    // 5. reset during WAIT
    cyc(); aif.if_req = 1'b1; aif.if_addr = 12'h010; #1;
    check("t5_gnt", aif.if_gnt, 1);
    cyc(); aif.if_req = 1'b0; #1;
    check("t5_busy_before", a_busy, 1);
    #1; rst_n = 1'b0; #1;
    check("t5_busy_async", a_busy, 0);
    check("t5_rdata_cleared", aif.if_rdata, 0);
    cyc(); cyc(); rst_n = 1'b1;
    ev = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      if (aif.if_rvalid | aif.d_rvalid) ev++;
    end
    check("t5_no_rvalid", ev, 0);
    cyc(); aif.if_req = 1'b1; aif.if_addr = 12'h010; #1;
    check("t5_regrant", aif.if_gnt, 1);
    check("t5_regrant_addr", aif.mem_addr, 12'h010);
    cyc(); aif.if_req = 1'b0;
    cyc(); #1;
    check("t5_rvalid", aif.if_rvalid, 1);
    check("t5_rdata", aif.if_rdata, 32'h0000_0093);

    // 6. MEM_LAT=3: ten back-to-back fetches on instance B
    ng = 0; nrv = 0;
    cyc(); bif.if_req = 1'b1; bif.if_addr = 12'h100;
    for (int k = 0; k < 60 && nrv < 10; k++) begin
      #1;
      if (bif.if_gnt) begin
        if (ng < 10) gq[ng] = k;
        ng++;
      end
      if (bif.if_rvalid) begin
        if (nrv < 10 && nrv < ng) begin
          check("t6_latency", k, gq[nrv] + 4);
          check("t6_rdata", bif.if_rdata, 32'hA000_0100 + 32'(nrv));
        end
        nrv++;
      end
      cyc();
      if (ng < 10) bif.if_addr = 12'h100 + 12'(ng);
      if (ng >= 10 && k + 1 == gq[9] + 4) bif.if_req = 1'b0;
    end
    bif.if_req = 1'b0;
    check("t6_grants", ng, 10);
    check("t6_rvalids", nrv, 10);
    cyc(); #1;
`ifdef MEM_ARB_PERF_EN
    check("t6_perf_if_gnt", b_pif, 32'd10);
    check("t6_perf_d_gnt", b_pd, 32'd0);
    check("t6_perf_stall", b_ps, 32'd30);
`endif
    check("t6_idle", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
